// File: rtl/apb_reg_slave_if.sv
// APB slave-side bus bundle for apb_reg_slave: request signals from the master,
// registered completion signals back from the slave.
interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   slave_paddr;
    logic                    slave_pprot;
    logic                    slave_psel;
    logic                    slave_penable;
    logic                    slave_pwrite;
    logic [DATA_WIDTH-1:0]   slave_pwdata;
    logic [DATA_WIDTH/8-1:0] slave_pstrb;
    logic                    slave_pready;
    logic [DATA_WIDTH-1:0]   slave_prdata;
    logic                    slave_pslverr;

    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
    // cycles (psel=1, penable=1); it completes in the access cycle where pready=1,
    // and prdata/pslverr are meaningful only in that cycle (zero otherwise).
    modport master (
        output slave_paddr, slave_pprot, slave_psel, slave_penable, slave_pwrite,
               slave_pwdata, slave_pstrb,
        input  slave_pready, slave_prdata, slave_pslverr
    );

    modport slave (
        input  slave_paddr, slave_pprot, slave_psel, slave_penable, slave_pwrite,
               slave_pwdata, slave_pstrb,
        output slave_pready, slave_prdata, slave_pslverr
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave: NUM_REGS word registers (index 0 is a read-only ID),
// fixed wait states, byte strobes and a protected upper half.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic                           clk,
    input  logic                           reset_n,
    apb_reg_slave_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [1:0]                     dbg_state
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           strb_q, strb_d;
    logic                    prot_q, prot_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [IW-1:0]           idx_q, idx_d;

    assign idx_q = addr_q[ADDR_WIDTH-1:2];
    assign idx_d = addr_d[ADDR_WIDTH-1:2];

    function automatic logic is_err(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic write, input logic prot);
        logic [IW-1:0] idx;
        idx = addr[ADDR_WIDTH-1:2];
        return (addr[1:0] != 2'b00) || (idx >= IW'(NUM_REGS)) ||
               (write && (idx == '0)) ||
               (write && !prot && (idx >= IW'(NUM_REGS / 2)));
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        regs_d    = regs_q;

        case (state_q)
            IDLE: begin
                // penable without a preceding setup is ignored
                if (bus.slave_psel && !bus.slave_penable) begin
                    addr_d  = bus.slave_paddr;
                    write_d = bus.slave_pwrite;
                    wdata_d = bus.slave_pwdata;
                    strb_d  = bus.slave_pstrb;
                    prot_d  = bus.slave_pprot;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.slave_psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.slave_penable) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                // Write lands on the edge that ends the completing access cycle.
                if (bus.slave_psel && bus.slave_penable && write_q &&
                    !is_err(addr_q, write_q, prot_q)) begin
                    for (int r = 1; r < NUM_REGS; r++) begin
                        if (idx_q == IW'(r)) begin
                            for (int b = 0; b < SW; b++) begin
                                if (strb_q[b]) regs_d[r][b*8 +: 8] = wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Response is built one cycle early so it leaves the flops with pready.
        if (state_d == RESP) begin
            pready_d = 1'b1;
            if (is_err(addr_d, write_d, prot_d)) begin
                pslverr_d = 1'b1;
            end else if (!write_d) begin
                if (idx_d == '0) prdata_d = ID_VALUE;
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (idx_d == IW'(r)) prdata_d = regs_q[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_out[r*DATA_WIDTH +: DATA_WIDTH] = (r == 0) ? ID_VALUE : regs_q[r];
        end
    end

    assign bus.slave_pready  = pready_q;
    assign bus.slave_prdata  = prdata_q;
    assign bus.slave_pslverr = pslverr_q;
    assign dbg_state         = state_q;
endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width, multiple of 8.
REQ-003 SHALL have parameter NUM_REGS, default 16, word registers implemented (2..64); register 0 is read-only ID.
REQ-004 SHALL have parameter WAIT_STATES, default 2, access cycles with pready low before completion (0..15).
REQ-005 SHALL have parameter ID_VALUE, default 32'hA0B0_0001, constant returned by register 0.
REQ-006 clk  input  1  single clock, all logic rising-edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 slave_paddr  input  ADDR_WIDTH  byte address; word index = paddr[ADDR_WIDTH-1:2].
REQ-009 slave_pprot  input  1  privilege flag; 1 = privileged.
REQ-010 slave_psel / slave_penable / slave_pwrite  input  1 each  APB select, enable, write.
REQ-011 slave_pwdata  input  DATA_WIDTH  write data.
REQ-012 slave_pstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-013 slave_pready  output  1  transfer completion, registered.
REQ-014 slave_prdata  output  DATA_WIDTH  read data, registered.
REQ-015 slave_pslverr  output  1  error response, registered.
REQ-016 reg_out  output  NUM_REGS*DATA_WIDTH  flattened current register contents, register n at bits [n*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP.
REQ-018 IDLE: psel=1 & penable=0 (setup) SHALL latch paddr, pwrite, pwdata, pstrb, pprot and load wait counter with WAIT_STATES; next state RESP if WAIT_STATES=0, else WAIT.
REQ-019 WAIT: counter decrements each cycle psel=1 & penable=1; on cycle counter reaches 1, next state RESP; pready stays 0.
REQ-020 Net effect: exactly WAIT_STATES access cycles with pready=0 precede the access cycle with pready=1.
REQ-021 RESP: pready=1 with prdata/pslverr valid for exactly one cycle; next state IDLE.
REQ-022 Error condition: paddr[1:0]!=0, OR word index >= NUM_REGS, OR write to index 0, OR write with pprot=0 to index >= NUM_REGS/2 (protected upper half).
REQ-023 Error transfer SHALL drive pslverr=1, prdata=0, and SHALL NOT modify any register.
REQ-024 Valid write SHALL update byte lane i of target register iff pstrb[i]=1, at the clock edge ending the RESP cycle; pstrb=0 completes OKAY with no change.
REQ-025 Valid read SHALL drive prdata = register contents (ID_VALUE for index 0) in RESP; pstrb ignored on reads.
REQ-026 prdata SHALL be 0 and pslverr 0 whenever pready=0.
REQ-027 Abort: psel=0 while in WAIT or RESP SHALL return FSM to IDLE next cycle, clear pready, commit no write.
REQ-028 Address/data/control changes during WAIT SHALL be ignored; latched setup values are used.
REQ-029 penable=1 observed in IDLE (protocol violation) SHALL be ignored; FSM stays IDLE.
REQ-030 Back-to-back: setup in the cycle after RESP SHALL be accepted with no idle gap.
REQ-031 reg_out SHALL reflect writes the cycle after commit; index 0 slice SHALL equal ID_VALUE.

Reset
REQ-032 reset_n=0 SHALL asynchronously force IDLE, counter 0, pready=0, prdata=0, pslverr=0, registers 1..NUM_REGS-1 = 0.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer; no partial write; first valid setup after release is accepted normally.

Verification
REQ-034 Write 0x0000_0004, data 0xDEADBEEF, pstrb 4'hF, pprot=0, WAIT_STATES=2 -> pready low 2 access cycles, high on 3rd, pslverr=0; read back 0xDEADBEEF; reg_out[63:32]=0xDEADBEEF.
REQ-035 Reg 1 = 0xDEADBEEF, write 0x0000_0004 data 0x1122_3344 pstrb 4'b0101 -> read 0xDE22BE44.
REQ-036 Read 0x000 -> ID_VALUE; write 0x000 -> pslverr=1, read 0x000 still ID_VALUE; read 0x040 (index 16) -> pslverr=1, prdata=0; read 0x006 -> pslverr=1.
REQ-037 Write 0x020 (index 8) pprot=0 -> pslverr=1, no change; same with pprot=1 data 0x55 -> OKAY, read 0x55.
REQ-038 Deassert psel during WAIT of write to 0x008 -> no pready, register 2 unchanged; reset_n pulsed during WAIT -> outputs 0, registers cleared, next read of 0x008 returns 0.
REQ-039 WAIT_STATES=0, back-to-back write 0x00C then read 0x00C -> pready high in first access cycle each, read returns written data, no idle cycle between transfers.
